// File: rtl/div8by4_seq.sv
// Sequential unsigned restoring divider: DW-bit dividend by VW-bit divisor,
// one quotient bit per clock behind a start/done handshake.
module div8by4_seq #(
   parameter int DW = 8,
   parameter int VW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          div_by_zero
);

   localparam int CW = (DW > 1) ? $clog2(DW) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIN  = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [VW-1:0] dvs_q, dvs_d;
   logic [VW-1:0] p_q, p_d;
   logic [DW-1:0] q_q, q_d;
   logic [DW-1:0] quot_q, quot_d;
   logic [VW-1:0] rem_q, rem_d;
   logic          dbz_q, dbz_d;

   // Stored remainder is always < divisor, so it fits VW bits; the shifted
   // partial remainder needs one extra bit before the trial subtraction.
   logic [VW:0]   shifted;
   logic          fits;

   assign shifted = {p_q, q_q[DW-1]};
   assign fits    = (shifted >= {1'b0, dvs_q});

   // NOTE: every variable gets a default first so no path leaves it unassigned
   // and no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvs_d   = dvs_q;
      p_d     = p_q;
      q_d     = q_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;

      case (state_q)
         S_IDLE, S_FIN: begin
            if (start) begin
               dvs_d = divisor;
               q_d   = dividend;
               p_d   = '0;
               cnt_d = '0;
               if (divisor != '0) begin
                  state_d = S_CALC;
               end else begin
                  state_d = S_FIN;
                  quot_d  = '1;
                  rem_d   = '0;
                  dbz_d   = 1'b1;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CALC: begin
            // The difference is below the divisor, so the low VW bits are exact.
            p_d   = fits ? (shifted[VW-1:0] - dvs_q) : shifted[VW-1:0];
            q_d   = {q_q[DW-2:0], fits};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(DW - 1)) begin
               state_d = S_FIN;
               quot_d  = q_d;
               rem_d   = p_d;
               dbz_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         dvs_q   <= '0;
         p_q     <= '0;
         q_q     <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvs_q   <= dvs_d;
         p_q     <= p_d;
         q_q     <= q_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy        = (state_q == S_CALC);
   assign done        = (state_q == S_FIN);
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div8by4_seq.sv
// Self-checking bench for div8by4_seq: behavioural model compared every cycle,
// directed literal cases, random traffic and an exhaustive sweep.
module tb_div8by4_seq;

   localparam int DW = 8;
   localparam int VW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          start = 1'b0;
   logic [DW-1:0] dividend = '0;
   logic [VW-1:0] divisor = '0;
   logic          busy;
   logic          done;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;
   logic          div_by_zero;

   int n_cmp  = 0;
   int n_fail = 0;

   div8by4_seq #(.DW(DW), .VW(VW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: an accepted operation finishes DW cycles later with
   // a/b and a%b; a zero divisor finishes on the next cycle with all-ones.
   int            m_left = 0;
   logic          m_done = 1'b0;
   logic [DW-1:0] m_q = '0;
   logic [VW-1:0] m_r = '0;
   logic          m_z = 1'b0;
   logic [DW-1:0] m_a = '0;
   logic [VW-1:0] m_b = '0;
   logic [DW-1:0] r_a = '0;
   logic [VW-1:0] r_b = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left = 0;
         m_done = 1'b0;
         m_q    = '0;
         m_r    = '0;
         m_z    = 1'b0;
      end else begin
         m_done = 1'b0;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_done = 1'b1;
               m_q    = m_a / m_b;
               m_r    = m_a % m_b;
               m_z    = 1'b0;
               r_a    = m_a;
               r_b    = m_b;
            end
         end else if (start) begin
            m_a = dividend;
            m_b = divisor;
            if (divisor == '0) begin
               m_done = 1'b1;
               m_q    = '1;
               m_r    = '0;
               m_z    = 1'b1;
            end else begin
               m_left = DW;
            end
         end
      end
   end

   int  done_cnt = 0;
   bit  count_en = 1'b0;

   always @(negedge clk) begin
      check("busy", busy, (m_left > 0));
      check("done", done, m_done);
      check("quotient", quotient, m_q);
      check("remainder", remainder, m_r);
      check("div_by_zero", div_by_zero, m_z);
      if (done && !div_by_zero && m_done && !m_z) begin
         check("invariant", 32'(quotient) * 32'(r_b) + 32'(remainder), 32'(r_a));
         check("rem_lt_div", (remainder < r_b), 1);
      end
      if (count_en && done) done_cnt++;
   end

   // Drives one start pulse once the model says the divider can accept, then
   // scrambles the operands to show they were captured.
   task automatic start_op(input logic [DW-1:0] a, input logic [VW-1:0] b);
      int w = 0;
      while (m_left != 0 && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (w >= 20) check("start_wait", w, 0);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      dividend = DW'($urandom);
      divisor  = VW'($urandom);
   endtask

   task automatic op_expect(input string tag, input logic [DW-1:0] a, input logic [VW-1:0] b,
                            input logic [DW-1:0] eq, input logic [VW-1:0] er, input logic ez,
                            input int elat);
      int lat = 1;
      int bc;
      start_op(a, b);
      bc = busy ? 1 : 0;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
         if (busy) bc++;
      end
      check({tag, " latency"}, lat, elat);
      check({tag, " busy_cycles"}, bc, ez ? 0 : DW);
      check({tag, " q"}, quotient, eq);
      check({tag, " r"}, remainder, er);
      check({tag, " dbz"}, div_by_zero, ez);
      check({tag, " model_q"}, m_q, eq);
      check({tag, " model_r"}, m_r, er);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #1;
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset q", quotient, 0);
      check("reset r", remainder, 0);
      check("reset dbz", div_by_zero, 0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);

      op_expect("200/7", 8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 9);
      op_expect("255/1", 8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 9);
      op_expect("9/15", 8'd9, 4'd15, 8'd0, 4'd9, 1'b0, 9);
      op_expect("0/5", 8'd0, 4'd5, 8'd0, 4'd0, 1'b0, 9);
      op_expect("100/0", 8'd100, 4'd0, 8'hFF, 4'd0, 1'b1, 1);
      op_expect("100/3", 8'd100, 4'd3, 8'd33, 4'd1, 1'b0, 9);

      // Divide by zero immediately from FIN gives back-to-back done.
      op_expect("17/0", 8'd17, 4'd0, 8'hFF, 4'd0, 1'b1, 1);
      op_expect("42/0", 8'd42, 4'd0, 8'hFF, 4'd0, 1'b1, 1);

      // Random single operations with random gaps, zero divisor included.
      for (int i = 0; i < 150; i++) begin
         start_op(DW'($urandom), VW'($urandom));
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      // Start held high with operands changing every cycle.
      start = 1'b1;
      for (int i = 0; i < 80; i++) begin
         dividend = DW'($urandom);
         divisor  = VW'($urandom_range(0, 15));
         @(negedge clk);
      end
      start = 1'b0;
      repeat (12) @(negedge clk);

      // Asynchronous reset during the 4th CALC cycle.
      op_expect("100/3b", 8'd100, 4'd3, 8'd33, 4'd1, 1'b0, 9);
      start_op(8'd77, 4'd5);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midreset busy", busy, 0);
      check("midreset done", done, 0);
      check("midreset q", quotient, 0);
      check("midreset r", remainder, 0);
      check("midreset dbz", div_by_zero, 0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (12) @(negedge clk);
      op_expect("50/6", 8'd50, 4'd6, 8'd8, 4'd2, 1'b0, 9);

      // Exhaustive sweep with random start gaps.
      repeat (2) @(negedge clk);
      done_cnt = 0;
      count_en = 1'b1;
      for (int a = 0; a < 256; a++) begin
         for (int b = 1; b < 16; b++) begin
            start_op(DW'(a), VW'(b));
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
      end
      repeat (DW + 4) @(negedge clk);
      count_en = 1'b0;
      check("sweep done count", done_cnt, 3840);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
